// File: rtl/pcie_pkg.sv
// Shared PCIe/DMA definitions: TLP header constants, register indices,
// DMA writer state type and a memory-write header builder.
package pcie_pkg;

  localparam logic [7:0]  MWR32_FMT_TYPE  = 8'h40;  // fmt 3DW+data, type MWr
  localparam logic        REG_DMABASE     = 1'b0;
  localparam logic        REG_DMACTRL     = 1'b1;
  localparam int unsigned TLP_QWS_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_MSI
  } dma_state_t;

  // Builds {DW1,DW0} of a 3DW memory-write header: TC0, no attributes,
  // tag 0, all byte enables set.
  function automatic logic [63:0] mk_mwr_hdr(input logic [15:0] req_id,
                                             input logic [9:0]  len_dw);
    logic [31:0] dw0;
    logic [31:0] dw1;
    dw0 = {MWR32_FMT_TYPE, 14'h0000, len_dw};
    dw1 = {req_id, 8'h00, 4'hF, 4'hF};
    return {dw1, dw0};
  endfunction

endpackage

// File: rtl/dma_tlp_writer_if.sv
// Bundle of register, source FIFO, TX stream and MSI signals around the
// DMA TLP writer. master = the writer, slave = its surroundings.
interface dma_tlp_writer_if;

  logic [12:0] cfgBusDev_in;
  logic        regAddr_in;
  logic [31:0] regWrData_in;
  logic        regWrValid_in;
  logic [63:0] srcData_in;
  logic        srcValid_in;
  logic        srcReady_out;
  logic [63:0] txData_out;
  logic        txValid_out;
  logic        txReady_in;
  logic        txSOP_out;
  logic        txEOP_out;
  logic        msiReq_out;
  logic [4:0]  msiNum_out;
  logic        msiAck_in;
  logic        busy_out;

  modport master (
    input  cfgBusDev_in, regAddr_in, regWrData_in, regWrValid_in,
    input  srcData_in, srcValid_in, txReady_in, msiAck_in,
    output srcReady_out, txData_out, txValid_out, txSOP_out, txEOP_out,
    output msiReq_out, msiNum_out, busy_out
  );

  modport slave (
    output cfgBusDev_in, regAddr_in, regWrData_in, regWrValid_in,
    output srcData_in, srcValid_in, txReady_in, msiAck_in,
    input  srcReady_out, txData_out, txValid_out, txSOP_out, txEOP_out,
    input  msiReq_out, msiNum_out, busy_out
  );

endinterface

// File: rtl/dma_tlp_writer.sv
// DMA responder: after DMABASE/DMACTRL are programmed, streams N memory-write
// TLPs of TLP_QWS quadwords from the source FIFO to the TX port, then raises MSI.
module dma_tlp_writer
  import pcie_pkg::*;
#(
  parameter int unsigned TLP_QWS = TLP_QWS_DEFAULT,
  parameter int unsigned MSI_NUM = 0
) (
  input  logic             clk_in,
  input  logic             rstn,
  dma_tlp_writer_if.master dma
);

  localparam int unsigned    QCW       = (TLP_QWS > 1) ? $clog2(TLP_QWS) : 1;
  localparam logic [QCW-1:0] QC_LAST   = QCW'(TLP_QWS - 1);
  localparam logic [31:0]    TLP_BYTES = 32'(TLP_QWS * 8);
  localparam logic [9:0]     LEN_DW    = 10'(2 * TLP_QWS);

  dma_state_t     state;
  logic [31:0]    base;
  logic [31:0]    addr;
  logic [15:0]    count;
  logic [QCW-1:0] qc;
  logic           data_xfer;

  assign data_xfer = (state == ST_DATA) && dma.srcValid_in && dma.txReady_in;

  // Control FSM plus DMA registers; registers are writable only while idle.
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      state <= ST_IDLE;
      base  <= '0;
      addr  <= '0;
      count <= '0;
      qc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dma.regWrValid_in) begin
            if (dma.regAddr_in == REG_DMABASE) begin
              base <= {dma.regWrData_in[31:3], 3'b000};
            end else if ((dma.regAddr_in == REG_DMACTRL) &&
                         (dma.regWrData_in[15:0] != 16'd0)) begin
              count <= dma.regWrData_in[15:0];
              addr  <= base;
              qc    <= '0;
              state <= ST_HDR0;
            end
          end
        end
        ST_HDR0: if (dma.txReady_in) state <= ST_HDR1;
        ST_HDR1: begin
          if (dma.txReady_in) begin
            qc    <= '0;
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_xfer) begin
            if (qc == QC_LAST) begin
              qc    <= '0;
              addr  <= addr + TLP_BYTES;
              count <= count - 16'd1;
              state <= (count == 16'd1) ? ST_MSI : ST_HDR0;
            end else begin
              qc <= qc + QCW'(1);
            end
          end
        end
        ST_MSI:  if (dma.msiAck_in) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from state; in DATA the source beat passes straight through
  // so a source stall drops txValid instead of inserting a bubble beat.
  always_comb begin
    dma.txValid_out  = 1'b0;
    dma.txSOP_out    = 1'b0;
    dma.txEOP_out    = 1'b0;
    dma.txData_out   = '0;
    dma.srcReady_out = 1'b0;
    dma.msiReq_out   = 1'b0;
    dma.msiNum_out   = 5'(MSI_NUM);
    dma.busy_out     = (state != ST_IDLE) && !((state == ST_MSI) && dma.msiAck_in);
    case (state)
      ST_HDR0: begin
        dma.txValid_out = 1'b1;
        dma.txSOP_out   = 1'b1;
        dma.txData_out  = mk_mwr_hdr({dma.cfgBusDev_in, 3'b000}, LEN_DW);
      end
      ST_HDR1: begin
        dma.txValid_out = 1'b1;
        dma.txData_out  = {32'h0, addr};
      end
      ST_DATA: begin
        dma.txValid_out  = dma.srcValid_in;
        dma.txData_out   = dma.srcData_in;
        dma.txEOP_out    = (qc == QC_LAST);
        dma.srcReady_out = data_xfer;
      end
      ST_MSI:  dma.msiReq_out = 1'b1;
      default: ;
    endcase
  end

endmodule
